// File: rtl/pwm_counter.sv
// PWM timebase counter: prescaled up/down count with shadowed period, prescale
// and direction that are only adopted while idle, on clear, or at a wrap.
module pwm_counter #(
   parameter int CW = 16,
   parameter int PW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [CW-1:0] period,
   input  logic          en,
   input  logic          count_reset,
   input  logic          upnotdown,
   input  logic [PW-1:0] prescale,
   output logic [CW-1:0] counter_val,
   output logic [CW-1:0] active_period,
   output logic          tick,
   output logic          ovf,
   output logic          unf
);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] aper_q, aper_d;
   logic [PW-1:0] apre_q, apre_d;
   logic [PW-1:0] pcnt_q, pcnt_d;
   logic          adir_q, adir_d;
   logic          tick_q, tick_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;
   logic          load_s;
   logic [CW-1:0] restart_s;

   // Next-state: clear beats disable beats counting; shadows load on LOAD events.
   always_comb begin
      cnt_d     = cnt_q;
      pcnt_d    = pcnt_q;
      tick_d    = 1'b0;
      ovf_d     = 1'b0;
      unf_d     = 1'b0;
      load_s    = 1'b0;
      restart_s = upnotdown ? {CW{1'b0}} : period;

      if (count_reset) begin
         load_s = 1'b1;
         pcnt_d = {PW{1'b0}};
         cnt_d  = restart_s;
      end else if (!en) begin
         load_s = 1'b1;
         pcnt_d = {PW{1'b0}};
      end else if (pcnt_q != apre_q) begin
         pcnt_d = pcnt_q + PW'(1);
      end else begin
         pcnt_d = {PW{1'b0}};
         tick_d = 1'b1;
         if (adir_q) begin
            // >= also catches a count left above a period lowered while disabled
            if (cnt_q < aper_q) begin
               cnt_d = cnt_q + CW'(1);
            end else begin
               ovf_d  = 1'b1;
               load_s = 1'b1;
               cnt_d  = restart_s;
            end
         end else begin
            if (cnt_q != {CW{1'b0}}) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               unf_d  = 1'b1;
               load_s = 1'b1;
               cnt_d  = restart_s;
            end
         end
      end

      if (load_s) begin
         aper_d = period;
         apre_d = prescale;
         adir_d = upnotdown;
      end else begin
         aper_d = aper_q;
         apre_d = apre_q;
         adir_d = adir_q;
      end
   end

   // State and pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= {CW{1'b0}};
         aper_q <= {CW{1'b0}};
         apre_q <= {PW{1'b0}};
         pcnt_q <= {PW{1'b0}};
         adir_q <= 1'b0;
         tick_q <= 1'b0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         aper_q <= aper_d;
         apre_q <= apre_d;
         pcnt_q <= pcnt_d;
         adir_q <= adir_d;
         tick_q <= tick_d;
         ovf_q  <= ovf_d;
         unf_q  <= unf_d;
      end
   end

   assign counter_val   = cnt_q;
   assign active_period = aper_q;
   assign tick          = tick_q;
   assign ovf           = ovf_q;
   assign unf           = unf_q;

endmodule

// File: tb/tb_pwm_counter.sv
// Bench for pwm_counter: directed and random programming, behavioural model
// predictions queued per cycle and compared by an independent monitor.
module tb_pwm_counter;

   localparam int CW = 16;
   localparam int PW = 8;

   logic          clk;
   logic          rst_n;
   logic [CW-1:0] period;
   logic          en;
   logic          count_reset;
   logic          upnotdown;
   logic [PW-1:0] prescale;
   logic [CW-1:0] counter_val;
   logic [CW-1:0] active_period;
   logic          tick;
   logic          ovf;
   logic          unf;

   pwm_counter #(.CW(CW), .PW(PW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .period        (period),
      .en            (en),
      .count_reset   (count_reset),
      .upnotdown     (upnotdown),
      .prescale      (prescale),
      .counter_val   (counter_val),
      .active_period (active_period),
      .tick          (tick),
      .ovf           (ovf),
      .unf           (unf)
   );

   typedef struct {
      int unsigned cnt;
      int unsigned aper;
      bit          tick;
      bit          ovf;
      bit          unf;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state: what the counter is doing, in plain integers.
   int unsigned m_cnt, m_per, m_pre, m_phase;
   bit          m_up;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input int unsigned act, input int unsigned req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: outputs are valid every cycle, so each pushed prediction is
   // compared on the falling edge after the clock edge that produced it.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("counter_val", counter_val, e.cnt);
            check("active_period", active_period, e.aper);
            check("tick", tick, e.tick);
            check("ovf", ovf, e.ovf);
            check("unf", unf, e.unf);
         end
      end
   end

   task automatic model_reset();
      m_cnt = 0; m_per = 0; m_pre = 0; m_phase = 0; m_up = 1'b0;
   endtask

   // One clock of stimulus: apply inputs, let the edge happen, predict result.
   task automatic cyc(input int unsigned p, input int unsigned ps, input bit ud,
                      input bit e, input bit cr);
      exp_t x;
      bit   adopt;
      period = p[CW-1:0]; prescale = ps[PW-1:0]; upnotdown = ud;
      en = e; count_reset = cr;
      @(posedge clk);
      x.tick = 1'b0; x.ovf = 1'b0; x.unf = 1'b0;
      adopt = 1'b0;
      if (cr) begin
         adopt = 1'b1; m_phase = 0;
         m_cnt = ud ? 0 : p;
      end else if (!e) begin
         adopt = 1'b1; m_phase = 0;
      end else if (m_phase < m_pre) begin
         m_phase++;
      end else begin
         m_phase = 0; x.tick = 1'b1;
         if (m_up && m_cnt >= m_per) begin
            x.ovf = 1'b1; adopt = 1'b1; m_cnt = ud ? 0 : p;
         end else if (!m_up && m_cnt == 0) begin
            x.unf = 1'b1; adopt = 1'b1; m_cnt = ud ? 0 : p;
         end else if (m_up) begin
            m_cnt++;
         end else begin
            m_cnt--;
         end
      end
      if (adopt) begin
         m_per = p; m_pre = ps; m_up = ud;
      end
      x.cnt = m_cnt; x.aper = m_per;
      exp_q.push_back(x);
      @(negedge clk);
   endtask

   initial begin
      int unsigned rp, rps;
      bit          rud, ren, rcr;
      int          wait_cnt;
      rst_n = 1'b0; period = '0; prescale = '0; upnotdown = 1'b0;
      en = 1'b0; count_reset = 1'b0;
      model_reset();
      #3;
      check("rst counter_val", counter_val, 0);
      check("rst active_period", active_period, 0);
      check("rst tick", tick, 0);
      check("rst ovf", ovf, 0);
      check("rst unf", unf, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Up count, no prescale.
      cyc(4, 0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 12; i++) cyc(4, 0, 1'b1, 1'b1, 1'b0);
      // Prescale 3, period 2.
      cyc(2, 3, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 26; i++) cyc(2, 3, 1'b1, 1'b1, 1'b0);
      // Down count.
      cyc(3, 0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) cyc(3, 0, 1'b0, 1'b1, 1'b0);
      // Shadow period: write 3 at count 5 of a period-10 cycle.
      cyc(10, 0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) cyc(10, 0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 14; i++) cyc(3, 0, 1'b1, 1'b1, 1'b0);
      // Direction change mid-cycle takes effect at the wrap.
      for (int i = 0; i < 8; i++) cyc(3, 0, 1'b0, 1'b1, 1'b0);
      // period = 0, prescale 1.
      cyc(0, 1, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) cyc(0, 1, 1'b1, 1'b1, 1'b0);
      // Lower period below count while disabled, then enable.
      cyc(20, 0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 9; i++) cyc(20, 0, 1'b1, 1'b1, 1'b0);
      cyc(4, 0, 1'b1, 1'b0, 1'b0);
      cyc(4, 0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cyc(4, 0, 1'b1, 1'b1, 1'b0);
      // count_reset held two cycles at count 7 while enabled.
      cyc(20, 0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 7; i++) cyc(20, 0, 1'b1, 1'b1, 1'b0);
      cyc(20, 0, 1'b1, 1'b1, 1'b1);
      cyc(20, 0, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) cyc(20, 0, 1'b1, 1'b1, 1'b0);

      // Async reset mid-count, checked before the next clock edge.
      #1 rst_n = 1'b0;
      #1;
      check("midrst counter_val", counter_val, 0);
      check("midrst active_period", active_period, 0);
      check("midrst tick", tick, 0);
      check("midrst ovf", ovf, 0);
      check("midrst unf", unf, 0);
      model_reset();
      #1 rst_n = 1'b1;

      // Random programming.
      rp = 5; rps = 0; rud = 1'b1;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 15) == 0) rp  = $urandom_range(0, 12);
         if ($urandom_range(0, 15) == 0) rps = $urandom_range(0, 3);
         if ($urandom_range(0, 31) == 0) rud = ~rud;
         ren = ($urandom_range(0, 9) != 0);
         rcr = ($urandom_range(0, 39) == 0);
         cyc(rp, rps, rud, ren, rcr);
      end

      wait_cnt = 0;
      while (exp_q.size() > 0 && wait_cnt < 10) begin
         @(negedge clk);
         wait_cnt++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pwm_counter.md
Name: pwm_counter

Overview:
- Timebase counter of the PWM generator.
- Consumes the counter programming fields from the register block: period, en, count_reset, upnotdown, prescale.
- Produces counter_val, which goes back to the register block for readback and forward to the PWM output stage.
- Adds a prescaler and shadow (double-buffered) period, prescale and direction, so reprogramming mid-cycle never produces a truncated or glitched PWM cycle.

Parameters:
- CW, 16, counter/period width
- PW, 8, prescale width

Ports:
- clk  input  1  peripheral clock
- rst_n  input  1  reset, asynchronous, active-low
- period  input  CW  programmed period (shadow source)
- en  input  1  counter enable
- count_reset  input  1  synchronous counter clear (level; may be held several cycles)
- upnotdown  input  1  1 = count up, 0 = count down (shadow source)
- prescale  input  PW  programmed prescale (shadow source)
- counter_val  output  CW  current count, registered
- active_period  output  CW  period currently in effect (for PWM stage)
- tick  output  1  one-cycle pulse, counter advanced this edge
- ovf  output  1  one-cycle pulse, up-count wrap occurred
- unf  output  1  one-cycle pulse, down-count wrap occurred

Behaviour:
- Reset (async, rst_n=0) clears everything: counter_val=0, active_period=0, act_prescale=0, act_dir=0, pcnt=0, tick=0, ovf=0, unf=0. Outputs hold these until the first clk edge after rst_n deasserts.
- Internal state:
  - pcnt[PW-1:0] prescaler count
  - act_prescale, act_dir
  - active_period
- Shadow load event (LOAD): copies period/prescale/upnotdown into active_period/act_prescale/act_dir. LOAD occurs:
  - every edge while en=0
  - every edge while count_reset=1
  - on every wrap
- Priority per edge, highest first:
  1. count_reset=1: LOAD; pcnt<=0; counter_val<=0 if upnotdown=1, else period (new values). tick/ovf/unf = 0.
  2. en=0: LOAD; counter_val holds; pcnt<=0; pulses 0.
  3. en=1:
     - If pcnt != act_prescale: pcnt++; counter_val holds; pulses 0.
     - Else: pcnt<=0; tick<=1; step counter as below.
- Step, up mode (act_dir=1):
  - counter_val < active_period: counter_val+1.
  - counter_val >= active_period: wrap, ovf<=1, LOAD. Next value: 0 if new dir=1, new period if new dir=0.
- Step, down mode (act_dir=0):
  - counter_val != 0: counter_val-1.
  - counter_val == 0: wrap, unf<=1, LOAD. Next value: new period if new dir=0, 0 if new dir=1.
- Tick rate: one tick every (act_prescale+1) enabled cycles. Prescale 0 → advance every enabled clk.
- Up-mode cycle length: (active_period+1) ticks.
- Pulses are registered and coincide with the cycle in which counter_val shows the post-wrap value.
- Period changes while enabled take effect only at the next wrap. counter_val never exceeds the active period because of a mid-cycle write.
- period=0:
  - Counter stays 0.
  - Every tick is a wrap: ovf (up) or unf (down) every tick.
- counter_val > active_period can only arise while en=0 (period lowered while disabled).
  - Up mode: next tick wraps immediately with ovf.
  - Down mode: counts down normally.
- Direction change while enabled takes effect at the next wrap. The pulse type reflects the boundary actually reached (old direction).
- count_reset and en simultaneous: count_reset wins.
- count_reset held 2 cycles: counter stays at its reset value both cycles. Counting resumes on the first edge after release, with pcnt=0.
- Arithmetic is unsigned, CW bits. No wrap through 2^CW-1 is possible: up-count is bounded by active_period, down-count by 0.
- Async reset mid-count: immediate return to reset values; no pulse emitted.

Test Plan:
- Up count, no prescale. Reset, period=4, prescale=0, upnotdown=1, pulse count_reset, en=1 → counter_val 0,1,2,3,4,0,1…; ovf high exactly on cycles showing the post-wrap 0; tick high every cycle.
- Prescale. period=2, prescale=3, up → each value held 4 cycles; tick every 4th cycle; ovf every 12 cycles.
- Down count. period=3, upnotdown=0, count_reset then en → 3,2,1,0,3…; unf on each 3 after a 0; ovf never asserts.
- Shadow period. Up mode, period=10, at counter_val=5 write period=3 → counts to 10, wraps with ovf, then 0..3 repeating; active_period changes 10→3 on the wrap edge only.
- Edge cases:
  - period=0, up, prescale=1 → counter_val stays 0, ovf every 2 cycles.
  - With en=0, set period below current count, then en=1 → immediate wrap with ovf on first tick.
- Reset/priority:
  - count_reset held 2 cycles while en=1 at counter_val=7 → 0 for both cycles, then 1 on the next edge.
  - Assert rst_n=0 mid-count → all outputs 0 before the next clk edge.
